// File: rtl/brcomp_pkg.sv
// Shared types and helpers for the sequential branch comparator.
// Branch encodings, FSM state type and the funct3-to-taken decode.
package brcomp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Illegal encodings 010/011 never take the branch.
    function automatic logic br_taken(input logic [2:0] funct3,
                                      input logic       less,
                                      input logic       equal);
        case (funct3)
            F3_BEQ:  br_taken = equal;
            F3_BNE:  br_taken = !equal;
            F3_BLT:  br_taken = less;
            F3_BGE:  br_taken = !less;
            F3_BLTU: br_taken = less;
            F3_BGEU: br_taken = !less;
            default: br_taken = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/brcomp_slice_cmp.sv
// Combinational unsigned compare of one operand slice.
module brcomp_slice_cmp #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic         o_lt,
    output logic         o_eq
);

    assign o_lt = (i_a < i_b);
    assign o_eq = (i_a == i_b);

endmodule

// File: rtl/brcomp_seq_ctrl.sv
// Multi-cycle branch comparator: one SLICE_W slice per cycle, MSB slice first.
// Define BRCOMP_EARLY_EXIT_EN to stop on the first differing slice.
module brcomp_seq_ctrl
    import brcomp_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int SLICE_W = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [2:0]      br_funct3_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic            br_taken_o,
    output logic            br_less_o,
    output logic            br_equal_o,
    output logic            busy_o
);

    localparam int NSLICE = XLEN / SLICE_W;
    localparam int IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(NSLICE - 1);

    state_e               r_state;
    logic [XLEN-1:0]      r_a;
    logic [XLEN-1:0]      r_b;
    logic [2:0]           r_funct3;
    logic [IDX_W-1:0]     r_idx;
    logic                 r_less;
    logic                 r_equal;
    logic                 r_taken;

    logic [XLEN-1:0]      w_bias;
    logic [SLICE_W-1:0]   w_a_slice;
    logic [SLICE_W-1:0]   w_b_slice;
    logic                 w_lt;
    logic                 w_eq;
    logic                 w_accept;
    logic                 w_finish;
    logic                 w_less_nxt;
    logic                 w_equal_nxt;

    // Flipping the sign bit turns a signed compare into an unsigned one.
    assign w_bias    = br_funct3_i[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    assign w_accept  = (r_state == IDLE) && req_valid_i;
    assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
    assign w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W];

    brcomp_slice_cmp #(.W(SLICE_W)) u_slice_cmp (
        .i_a  (w_a_slice),
        .i_b  (w_b_slice),
        .o_lt (w_lt),
        .o_eq (w_eq)
    );

`ifdef BRCOMP_EARLY_EXIT_EN
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_finish    = !w_eq || (r_idx == '0);
        w_less_nxt  = w_lt;
        w_equal_nxt = w_eq;
    end
`else
    logic r_found;
    logic r_lt_sticky;

    // The first differing slice decides; later slices are still walked but ignored.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_found     <= 1'b0;
            r_lt_sticky <= 1'b0;
        end else if (w_accept) begin
            r_found     <= 1'b0;
            r_lt_sticky <= 1'b0;
        end else if ((r_state == CMP) && !r_found && !w_eq) begin
            r_found     <= 1'b1;
            r_lt_sticky <= w_lt;
        end
    end

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        w_finish    = (r_idx == '0);
        w_less_nxt  = r_found ? r_lt_sticky : w_lt;
        w_equal_nxt = !r_found && w_eq;
    end
`endif

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: operand registers are reset too, keeping the slice mux inputs defined.
            r_state  <= IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_funct3 <= '0;
            r_idx    <= '0;
            r_less   <= 1'b0;
            r_equal  <= 1'b0;
            r_taken  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= rs1_data_i ^ w_bias;
                        r_b      <= rs2_data_i ^ w_bias;
                        r_funct3 <= br_funct3_i;
                        r_idx    <= IDX_MSB;
                        r_state  <= CMP;
                    end
                end
                CMP: begin
                    if (w_finish) begin
                        r_less  <= w_less_nxt;
                        r_equal <= w_equal_nxt;
                        r_taken <= br_taken(r_funct3, w_less_nxt, w_equal_nxt);
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx - IDX_W'(1);
                    end
                end
                DONE: begin
                    if (rsp_ready_i) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req_ready_o = (r_state == IDLE);
    assign rsp_valid_o = (r_state == DONE);
    assign busy_o      = (r_state != IDLE);
    assign br_less_o   = r_less;
    assign br_equal_o  = r_equal;
    assign br_taken_o  = r_taken;

endmodule

// File: tb/tb_brcomp_seq_ctrl.sv
// Directed bench for brcomp_seq_ctrl; latency expectations follow BRCOMP_EARLY_EXIT_EN.
module tb_brcomp_seq_ctrl;
    import brcomp_pkg::*;

    localparam int NSLICE = 4;
`ifdef BRCOMP_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [2:0]  br_funct3_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic        br_taken_o;
    logic        br_less_o;
    logic        br_equal_o;
    logic        busy_o;

    int tests_run    = 0;
    int tests_failed = 0;

    brcomp_seq_ctrl #(.XLEN(32), .SLICE_W(8)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .br_funct3_i (br_funct3_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .br_taken_o  (br_taken_o),
        .br_less_o   (br_less_o),
        .br_equal_o  (br_equal_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Issue one request and check latency and results; returns #1 after the handshake edge.
    task automatic run_branch(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] f3, input int k_early,
                              input logic exp_less, input logic exp_equal, input logic exp_taken);
        int exp_k;
        int cnt;
        int waitc;
        exp_k = EARLY ? k_early : NSLICE;
        waitc = 0;
        while (req_ready_o !== 1'b1 && waitc < 20) begin
            @(posedge clk_i); #1;
            waitc++;
        end
        tests_run++;
        if (req_ready_o !== 1'b1) begin
            $display("FAIL %s ready: req_ready_o=%b, required 1", name, req_ready_o);
            tests_failed++;
            return;
        end
        req_valid_i = 1'b1;
        rs1_data_i  = a;
        rs2_data_i  = b;
        br_funct3_i = f3;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        rs1_data_i  = ~a;
        rs2_data_i  = ~b;
        br_funct3_i = ~f3;
        cnt = 0;
        while (rsp_valid_o !== 1'b1 && cnt < 20) begin
            @(posedge clk_i); #1;
            cnt++;
        end
        tests_run++;
        if (cnt != exp_k) begin
            $display("FAIL %s latency: rsp_valid after %0d CMP cycles, required %0d", name, cnt, exp_k);
            tests_failed++;
            if (cnt >= 20) return;
        end
        tests_run++;
        if ({br_less_o, br_equal_o, br_taken_o, busy_o, req_ready_o} !==
            {exp_less, exp_equal, exp_taken, 1'b1, 1'b0}) begin
            $display("FAIL %s result: less/equal/taken/busy/ready=%b%b%b%b%b, required %b%b%b10",
                     name, br_less_o, br_equal_o, br_taken_o, busy_o, req_ready_o,
                     exp_less, exp_equal, exp_taken);
            tests_failed++;
        end
        @(posedge clk_i); #1;
        tests_run++;
        if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin
            $display("FAIL %s handshake: rsp_valid=%b req_ready=%b, required 0 1",
                     name, rsp_valid_o, req_ready_o);
            tests_failed++;
        end
    endtask

    task automatic test_reset();
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        rs1_data_i  = '0;
        rs2_data_i  = '0;
        br_funct3_i = '0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        tests_run++;
        if ({rsp_valid_o, br_taken_o, br_less_o, br_equal_o, busy_o, req_ready_o} !== 6'b000001) begin
            $display("FAIL reset: valid/taken/less/equal/busy/ready=%b%b%b%b%b%b, required 000001",
                     rsp_valid_o, br_taken_o, br_less_o, br_equal_o, busy_o, req_ready_o);
            tests_failed++;
        end
    endtask

    task automatic test_compares();
        run_branch("beq_equal",   32'h1234_5678, 32'h1234_5678, F3_BEQ,  4, 1'b0, 1'b1, 1'b1);
        run_branch("blt_neg",     32'hFFFF_FFFF, 32'h0000_0001, F3_BLT,  1, 1'b1, 1'b0, 1'b1);
        run_branch("bltu_big",    32'hFFFF_FFFF, 32'h0000_0001, F3_BLTU, 1, 1'b0, 1'b0, 1'b0);
        run_branch("bgeu_lsb",    32'h0000_0100, 32'h0000_0101, F3_BGEU, 4, 1'b1, 1'b0, 1'b0);
        run_branch("bne_lsb",     32'h1234_5678, 32'h1234_5600, F3_BNE,  4, 1'b0, 1'b0, 1'b1);
        run_branch("bge_min",     32'h8000_0000, 32'h7FFF_FFFF, F3_BGE,  1, 1'b1, 1'b0, 1'b0);
        run_branch("blt_pos_neg", 32'h0000_0005, 32'hFFFF_FFFD, F3_BLT,  1, 1'b0, 1'b0, 1'b0);
        run_branch("bge_slice2",  32'h00AB_0000, 32'h00AC_0000, F3_BGE,  2, 1'b1, 1'b0, 1'b0);
        run_branch("bltu_slice2", 32'h00AB_0000, 32'h00AC_0000, F3_BLTU, 2, 1'b1, 1'b0, 1'b1);
    endtask

    task automatic test_illegal_funct3();
        run_branch("f3_010_eq", 32'hCAFE_F00D, 32'hCAFE_F00D, 3'b010, 4, 1'b0, 1'b1, 1'b0);
        run_branch("f3_011_lt", 32'h0000_0001, 32'h0000_0002, 3'b011, 4, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_branch("b2b_first", 32'h0000_0010, 32'h0000_0020, F3_BLTU, 4, 1'b1, 1'b0, 1'b1);
        tests_run++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0) begin
            $display("FAIL b2b_ready: req_ready=%b busy=%b, required 1 0", req_ready_o, busy_o);
            tests_failed++;
        end
        run_branch("b2b_second", 32'h7000_0000, 32'h1000_0000, F3_BGEU, 1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        int cnt;
        rsp_ready_i = 1'b0;
        req_valid_i = 1'b1;
        rs1_data_i  = 32'h0000_0100;
        rs2_data_i  = 32'h0000_0101;
        br_funct3_i = F3_BLTU;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        cnt = 0;
        while (rsp_valid_o !== 1'b1 && cnt < 20) begin
            @(posedge clk_i); #1;
            cnt++;
        end
        tests_run++;
        if (rsp_valid_o !== 1'b1) begin
            $display("FAIL bp_wait: rsp_valid never rose, got %b, required 1", rsp_valid_o);
            tests_failed++;
            rsp_ready_i = 1'b1;
            return;
        end
        for (int i = 0; i < 3; i++) begin
            req_valid_i = 1'b1;
            rs1_data_i  = 32'h5555_5555;
            rs2_data_i  = 32'h5555_5555;
            br_funct3_i = F3_BEQ;
            tests_run++;
            if ({rsp_valid_o, br_less_o, br_equal_o, br_taken_o, req_ready_o, busy_o} !== 6'b110101) begin
                $display("FAIL bp_hold%0d: valid/less/equal/taken/ready/busy=%b%b%b%b%b%b, required 110101",
                         i, rsp_valid_o, br_less_o, br_equal_o, br_taken_o, req_ready_o, busy_o);
                tests_failed++;
            end
            @(posedge clk_i); #1;
        end
        rsp_ready_i = 1'b1;
        tests_run++;
        if ({rsp_valid_o, br_less_o, br_equal_o, br_taken_o} !== 4'b1101) begin
            $display("FAIL bp_release: valid/less/equal/taken=%b%b%b%b, required 1101",
                     rsp_valid_o, br_less_o, br_equal_o, br_taken_o);
            tests_failed++;
        end
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        tests_run++;
        if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0 || req_ready_o !== 1'b1) begin
            $display("FAIL bp_after: valid=%b busy=%b ready=%b, required 0 0 1",
                     rsp_valid_o, busy_o, req_ready_o);
            tests_failed++;
        end
        @(posedge clk_i); #1;
        tests_run++;
        if (busy_o !== 1'b0) begin
            $display("FAIL bp_ignored: busy=%b, required 0", busy_o);
            tests_failed++;
        end
    endtask

    task automatic test_reset_mid_cmp();
        int seen;
        req_valid_i = 1'b1;
        rs1_data_i  = 32'h1234_5678;
        rs2_data_i  = 32'h1234_5678;
        br_funct3_i = F3_BEQ;
        @(posedge clk_i); #1;
        req_valid_i = 1'b0;
        tests_run++;
        if (busy_o !== 1'b1 || rsp_valid_o !== 1'b0) begin
            $display("FAIL rst_cmp_busy: busy=%b valid=%b, required 1 0", busy_o, rsp_valid_o);
            tests_failed++;
        end
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        tests_run++;
        if ({rsp_valid_o, busy_o, req_ready_o, br_taken_o, br_less_o, br_equal_o} !== 6'b001000) begin
            $display("FAIL rst_cmp_state: valid/busy/ready/taken/less/equal=%b%b%b%b%b%b, required 001000",
                     rsp_valid_o, busy_o, req_ready_o, br_taken_o, br_less_o, br_equal_o);
            tests_failed++;
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk_i); #1;
            if (rsp_valid_o !== 1'b0 || busy_o !== 1'b0) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            $display("FAIL rst_cmp_abort: %0d cycles with activity after reset, required 0", seen);
            tests_failed++;
        end
    endtask

    initial begin
        test_reset();
        test_compares();
        test_illegal_funct3();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_cmp();
        run_branch("post_reset", 32'h0000_0000, 32'h0000_0001, F3_BNE, 4, 1'b1, 1'b0, 1'b1);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
